// File: rtl/div_half_precision.sv
// rtl/div_half_precision.sv - binary16 divider, round-to-nearest-even, one-cycle registered latency
// Subnormal operands read as zero; results outside the normal range saturate to Inf/zero with the exception flag.
module div_half_precision (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [15:0] i_Dividend,
  input  logic [15:0] i_Divisor,
  output logic [15:0] o_Quotient,
  output logic        o_Exception
);

  localparam logic [15:0] QNAN = 16'h7E00;

  logic       sign;
  logic [4:0] ea, eb;
  logic [9:0] fa, fb;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sign   = i_Dividend[15] ^ i_Divisor[15];
  assign ea     = i_Dividend[14:10];
  assign eb     = i_Divisor[14:10];
  assign fa     = i_Dividend[9:0];
  assign fb     = i_Divisor[9:0];
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
  assign a_inf  = (ea == 5'h1F) && (fa == 10'd0);
  assign b_inf  = (eb == 5'h1F) && (fb == 10'd0);
  assign a_nan  = (ea == 5'h1F) && (fa != 10'd0);
  assign b_nan  = (eb == 5'h1F) && (fb != 10'd0);

  logic [10:0] ma, mb;
  assign ma = {1'b1, fa};
  assign mb = {1'b1, fb};

  // Restoring division: qbits[13] is the integer bit, qbits[12:0] the fraction.
  logic [11:0] rem;
  logic [13:0] qbits;
  always_comb begin
    rem   = {1'b0, ma};
    qbits = '0;
    for (int i = 13; i >= 0; i--) begin
      if (rem >= {1'b0, mb}) begin
        qbits[i] = 1'b1;
        rem      = rem - {1'b0, mb};
      end
      rem = {rem[10:0], 1'b0};
    end
  end

  logic        lead;
  logic [9:0]  frac;
  logic        guard, sticky, round_up;
  logic [10:0] frac_sum;
  logic [6:0]  be;
  logic        ovf, unf;

  always_comb begin
    lead = qbits[13];
    if (lead) begin
      frac   = qbits[12:3];
      guard  = qbits[2];
      sticky = (|qbits[1:0]) | (|rem);
    end else begin
      frac   = qbits[11:2];
      guard  = qbits[1];
      sticky = qbits[0] | (|rem);
    end
    round_up = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {10'd0, round_up};
    // be is two's complement; range is roughly -15..45, so bit 6 is the sign.
    be  = {2'b00, ea} - {2'b00, eb} + 7'd15 - {6'd0, ~lead} + {6'd0, frac_sum[10]};
    ovf = !be[6] && (be >= 7'd31);
    unf = be[6] || (be == 7'd0);
  end

  logic [15:0] q_next;
  logic        exc_next;

  always_comb begin
    q_next   = 16'h0000;
    exc_next = 1'b0;
    if (a_nan || b_nan) begin
      q_next   = QNAN;
      exc_next = 1'b1;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      q_next   = QNAN;
      exc_next = 1'b1;
    end else if (a_inf) begin
      q_next   = {sign, 5'h1F, 10'd0};
      exc_next = 1'b1;
    end else if (b_inf) begin
      q_next   = {sign, 15'd0};
      exc_next = 1'b1;
    end else if (b_zero) begin
      q_next   = {sign, 5'h1F, 10'd0};
      exc_next = 1'b1;
    end else if (a_zero) begin
      q_next   = {sign, 15'd0};
      exc_next = 1'b0;
    end else if (ovf) begin
      q_next   = {sign, 5'h1F, 10'd0};
      exc_next = 1'b1;
    end else if (unf) begin
      q_next   = {sign, 15'd0};
      exc_next = 1'b1;
    end else begin
      q_next   = {sign, be[4:0], frac_sum[9:0]};
      exc_next = 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Quotient  <= 16'h0000;
      o_Exception <= 1'b0;
    end else begin
      o_Quotient  <= q_next;
      o_Exception <= exc_next;
    end
  end

endmodule

// File: tb/tb_div_half_precision.sv
// tb/tb_div_half_precision.sv - randomized and literal checks of div_half_precision against a real-arithmetic model
module tb_div_half_precision;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic [15:0] i_Dividend, i_Divisor;
  logic [15:0] o_Quotient;
  logic        o_Exception;

  always #5 i_Clock = ~i_Clock;

  div_half_precision dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Dividend (i_Dividend),
    .i_Divisor  (i_Divisor),
    .o_Quotient (o_Quotient),
    .o_Exception(o_Exception)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: divide the real values, then round to binary16 with ties-to-even.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int   ea, eb, fa, fb, e, mi, be;
    bit   az, bz, ai, bi, an, bn;
    real  q, m, r;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
    an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
    if (an || bn) return {1'b1, 16'h7E00};
    if ((ai && bi) || (az && bz)) return {1'b1, 16'h7E00};
    if (ai) return {1'b1, s, 15'h7C00};
    if (bi) return {1'b1, s, 15'h0000};
    if (bz) return {1'b1, s, 15'h7C00};
    if (az) return {1'b0, s, 15'h0000};
    q = real'(1024 + fa) / real'(1024 + fb);
    e = ea - eb;
    while (q < 1.0) begin q = q * 2.0; e--; end
    while (q >= 2.0) begin q = q / 2.0; e++; end
    m  = q * 1024.0;
    mi = int'($floor(m));
    r  = m - $floor(m);
    if (r > 0.5 || (r == 0.5 && (mi % 2) == 1)) mi++;
    if (mi == 2048) begin mi = 1024; e++; end
    be = e + 15;
    if (be >= 31) return {1'b1, s, 15'h7C00};
    if (be <= 0)  return {1'b1, s, 15'h0000};
    return {1'b0, s, 5'(be), 10'(mi - 1024)};
  endfunction

  logic        lit_en = 1'b0;
  logic [15:0] lit_q = 16'h0;
  logic        lit_e = 1'b0;
  string       lit_name = "";

  logic        chk_en = 1'b0;
  logic [16:0] exp_model = 17'h0;
  logic        exp_lit_en = 1'b0;
  logic [15:0] exp_lit_q = 16'h0;
  logic        exp_lit_e = 1'b0;
  string       exp_lit_name = "";

  always @(posedge i_Clock) begin
    chk_en       <= 1'b1;
    exp_model    <= i_Reset ? 17'h0 : model(i_Dividend, i_Divisor);
    exp_lit_en   <= lit_en;
    exp_lit_q    <= lit_q;
    exp_lit_e    <= lit_e;
    exp_lit_name <= lit_name;
  end

  always @(negedge i_Clock) begin
    if (chk_en) begin
      vectors++;
      if ({o_Exception, o_Quotient} !== exp_model) begin
        miscompares++;
        $display("FAIL model: got q=%h exc=%b, expected q=%h exc=%b", o_Quotient, o_Exception, exp_model[15:0], exp_model[16]);
      end
      if (exp_lit_en) begin
        vectors++;
        if ({o_Exception, o_Quotient} !== {exp_lit_e, exp_lit_q}) begin
          miscompares++;
          $display("FAIL %s: got q=%h exc=%b, expected q=%h exc=%b", exp_lit_name, o_Quotient, o_Exception, exp_lit_q, exp_lit_e);
        end
        vectors++;
        if (exp_model !== {exp_lit_e, exp_lit_q}) begin
          miscompares++;
          $display("FAIL pin_%s: model q=%h exc=%b, literal q=%h exc=%b", exp_lit_name, exp_model[15:0], exp_model[16], exp_lit_q, exp_lit_e);
        end
      end
    end
  end

  task automatic step(input logic [15:0] a, input logic [15:0] b, input bit rst,
                      input bit le, input logic [15:0] lq, input bit lx, input string nm);
    i_Dividend = a;
    i_Divisor  = b;
    i_Reset    = rst;
    lit_en     = le;
    lit_q      = lq;
    lit_e      = lx;
    lit_name   = nm;
    @(posedge i_Clock);
    #1;
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] specials [8];
    int          k;
    specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h0400, 16'h7BFF};
    k = int'($urandom_range(0, 9));
    if (k == 0) return 16'($urandom);
    if (k == 1) return specials[$urandom_range(0, 7)];
    return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
  endfunction

  initial begin
    logic [15:0] a, b;
    step(16'h4000, 16'h3C00, 1'b1, 1'b1, 16'h0000, 1'b0, "reset0");
    step(16'h4000, 16'h3C00, 1'b1, 1'b1, 16'h0000, 1'b0, "reset1");
    step(16'h4000, 16'h3C00, 1'b0, 1'b1, 16'h4000, 1'b0, "two_over_one");
    step(16'h3C00, 16'h4200, 1'b0, 1'b1, 16'h3555, 1'b0, "one_third");
    step(16'hC500, 16'h4000, 1'b0, 1'b1, 16'hC100, 1'b0, "neg_2p5");
    step(16'h4B80, 16'h4B80, 1'b0, 1'b1, 16'h3C00, 1'b0, "x_over_x");
    step(16'h4B80, 16'h4B80, 1'b0, 1'b1, 16'h3C00, 1'b0, "x_over_x_held");
    step(16'h3C00, 16'h0000, 1'b0, 1'b1, 16'h7C00, 1'b1, "div_by_zero");
    step(16'h8000, 16'h0000, 1'b0, 1'b1, 16'h7E00, 1'b1, "zero_over_zero");
    step(16'h7E00, 16'h3C00, 1'b0, 1'b1, 16'h7E00, 1'b1, "nan_in");
    step(16'h0000, 16'hC000, 1'b0, 1'b1, 16'h8000, 1'b0, "zero_over_neg");
    step(16'h7BFF, 16'h0400, 1'b0, 1'b1, 16'h7C00, 1'b1, "overflow");
    step(16'h0400, 16'h7BFF, 1'b0, 1'b1, 16'h0000, 1'b1, "underflow");
    step(16'h7C00, 16'h7C00, 1'b0, 1'b1, 16'h7E00, 1'b1, "inf_over_inf");
    step(16'hFC00, 16'h3C00, 1'b0, 1'b1, 16'hFC00, 1'b1, "neginf_over_one");
    step(16'h3C00, 16'hFC00, 1'b0, 1'b1, 16'h8000, 1'b1, "one_over_neginf");
    step(16'h0001, 16'h3C00, 1'b0, 1'b1, 16'h0000, 1'b0, "subnormal_in");
    step(16'h4400, 16'h3800, 1'b0, 1'b1, 16'h4800, 1'b0, "four_over_half");
    for (int n = 0; n < 300; n++) begin
      a = rand_op();
      b = (n % 17 == 5) ? a : rand_op();
      if (n == 150)
        step(a, b, 1'b1, 1'b1, 16'h0000, 1'b0, "mid_reset");
      else
        step(a, b, 1'b0, 1'b0, 16'h0000, 1'b0, "");
    end
    step(16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h3C00, 1'b0, "final_one");
    @(negedge i_Clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_half_precision.md
Name: div_half_precision

Overview:
- Clocked IEEE-754 binary16 (half-precision) floating-point divider for the pipeline arithmetic modules.
- Computes Dividend / Divisor with round-to-nearest-even.
- Registers the 16-bit quotient plus an exception flag with a fixed one-cycle latency.
- Subnormal inputs are flushed to zero; subnormal results are flushed to zero and flagged.

Parameters:
- None. The format is fixed at 1 sign bit, 5 exponent bits (bias 15) and 10 fraction bits.

Ports:
- i_Clock  input  1  rising-edge clock
- i_Reset  input  1  synchronous active-high reset
- i_Dividend  input  16  binary16 dividend: [15] sign, [14:10] exponent, [9:0] fraction
- i_Divisor  input  16  binary16 divisor, same format
- o_Quotient  output  16  registered binary16 quotient
- o_Exception  output  1  registered flag; high when the result is not a normal, exact-range finite quotient of finite operands

Behaviour:
- Reset: synchronous, active-high, sampled at the rising edge. While asserted, o_Quotient=16'h0000 and o_Exception=0 at the next edge. Reset mid-operation discards the in-flight result.
- Latency and handshake:
  - Inputs are sampled every rising edge; there is no handshake.
  - The result appears on the outputs after that same edge and is held until the next edge (latency 1, throughput 1 per cycle).
  - Inputs held stable yield stable outputs.
- Sign: Dividend[15] XOR Divisor[15], applied to all results, including zero and Inf. NaN is always 16'h7E00.
- Operand classes:
  - Zero: exponent 0. Nonzero-fraction subnormals are treated as zero.
  - Inf: exponent 31, fraction 0.
  - NaN: exponent 31, fraction nonzero.
  - Normal: everything else.
- Special cases, in priority order:
  1. Any NaN operand -> 16'h7E00, exc=1.
  2. Inf/Inf or 0/0 -> 16'h7E00, exc=1.
  3. Inf/finite -> signed Inf (s,5'h1F,10'h0), exc=1.
  4. finite/Inf -> signed zero, exc=1.
  5. nonzero/0 -> signed Inf, exc=1.
  6. 0/nonzero -> signed zero, exc=0.
- Normal path:
  - Mantissas are ma={1,frac_a} and mb={1,frac_b}, 11 bits each.
  - Quotient q=ma/mb, computed to at least 13 significant bits plus a sticky bit (nonzero remainder), with q in (0.5,2).
  - Unbiased exponent e=ea-eb. If q<1, shift left by 1 and decrement e.
  - Round to nearest, ties to even, on the 10-bit fraction. Rounding carry renormalizes: mantissa becomes 1.0 and e increments.
  - Biased result be=e+15.
  - be>=31 -> overflow: signed Inf, exc=1.
  - be<=0 -> underflow: signed zero, exc=1.
  - Otherwise the normal result is output with exc=0.
- Exact results (e.g. powers of two, x/x) must be bit-exact.
- All inexact normal results must be within 0.5 ulp of the true quotient.
- Purely synchronous design: no latches and no combinational path from inputs to outputs.

Test Plan:
- Reset: assert i_Reset for 2 cycles with i_Dividend=16'h4000, i_Divisor=16'h3C00 -> outputs 16'h0000/0. Deassert -> one edge later, 16'h4000 (2.0/1.0=2.0), exc=0.
- Rounding and sign:
  - 16'h3C00/16'h4200 (1/3) -> 16'h3555, exc=0.
  - 16'hC500/16'h4000 (-5/2) -> 16'hC100 (-2.5), exc=0.
  - 16'h4B80/16'h4B80 -> 16'h3C00.
- Specials:
  - 16'h3C00/16'h0000 -> 16'h7C00, exc=1.
  - 16'h8000/16'h0000 -> 16'h7E00, exc=1.
  - 16'h7E00/16'h3C00 -> 16'h7E00, exc=1.
  - 16'h0000/16'hC000 -> 16'h8000, exc=0.
- Range:
  - 16'h7BFF/16'h0400 -> 16'h7C00, exc=1 (overflow).
  - 16'h0400/16'h7BFF -> 16'h0000, exc=1 (underflow).
- Streaming: 25+ back-to-back random operand pairs, one per cycle. Each output, one cycle later, must be within 0.5 ulp of a real-number reference, with exc matching the rules above. Asserting reset mid-stream zeroes the outputs at the next edge.
